// File: rtl/vdp_boot_pkg.sv
// Shared types and constants for the VDP boot sequencer: FSM state and clear phase
// encodings, the boot command record, and the VDP host port addresses.
package vdp_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_ACK,
        ST_RELEASE,
        ST_WAIT_IDLE,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        PH_TABLE,
        PH_CLR_ADDR_HI,
        PH_CLR_ADDR_LO,
        PH_CLR_DATA
    } phase_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] data;
    } cmd_t;

    localparam logic [4:0]  VDP_PORT_DATA   = 5'h00;
    localparam logic [4:0]  VDP_PORT_CTRL   = 5'h04;
    localparam int          VRAM_WORDS      = 32768;
    localparam logic [15:0] VRAM_WR_ADDR_HI = 16'h4000;
    localparam logic [15:0] VRAM_WR_ADDR_LO = 16'h0000;

    function automatic cmd_t make_cmd(input logic [4:0] a, input logic [15:0] data);
        cmd_t c;
        c.a    = a;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/vdp_boot_rom.sv
// Fixed boot table: register writes that put the VDP into its default video mode.
// Indices past the table return a harmless all-zero control-port word.
module vdp_boot_rom
    import vdp_boot_pkg::*;
(
    input  logic [5:0] i_idx,
    output cmd_t       o_cmd
);

    always_comb begin
        o_cmd = make_cmd(VDP_PORT_CTRL, 16'h0000);
        case (i_idx)
            6'd0:    o_cmd.data = 16'h8004;
            6'd1:    o_cmd.data = 16'h8144;
            6'd2:    o_cmd.data = 16'h8230;
            6'd3:    o_cmd.data = 16'h8C81;
            default: o_cmd.data = 16'h0000;
        endcase
    end

endmodule

// File: rtl/vdp_boot_sequencer.sv
// Boot-time VDP host-port master: replays the boot table with a DTACK handshake.
// Define VDP_BOOT_VRAM_CLEAR_EN to also zero all of VRAM after the table.
module vdp_boot_sequencer
    import vdp_boot_pkg::*;
#(
    parameter int NUM_CMDS       = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        vdp_sel,
    output logic [4:0]  vdp_a,
    output logic        vdp_rnw,
    output logic        vdp_uds_n,
    output logic        vdp_lds_n,
    output logic [15:0] vdp_di,
    input  logic        vdp_dtack_n
);

    localparam logic [5:0]  LAST_IDX = 6'(NUM_CMDS - 1);
    localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [12:0] r_cnt;
    logic        r_dtack_n_p0;
    logic        r_dtack_n_p1;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_sel;
    logic [4:0]  r_a;
    logic        r_rnw;
    logic        r_uds_n;
    logic        r_lds_n;
    logic [15:0] r_di;

    logic        w_ack;
    logic        w_tmo;
    logic [5:0]  w_rom_idx;
    cmd_t        w_rom_cmd;
    cmd_t        w_next_cmd;
    logic        w_finish;

    // DTACK crosses from the VDP clock domain: two-flop synchronizer, idle high
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_dtack_n_p0 <= 1'b1;
            r_dtack_n_p1 <= 1'b1;
        end else begin
            r_dtack_n_p0 <= vdp_dtack_n;
            r_dtack_n_p1 <= r_dtack_n_p0;
        end
    end

    assign w_ack = ~r_dtack_n_p1;
    assign w_tmo = (r_cnt >= TMO_LAST);

    // Start always loads entry 0; NEXT looks one entry ahead
    assign w_rom_idx = (r_state == ST_NEXT) ? r_idx + 6'd1 : 6'd0;

    vdp_boot_rom u_rom (
        .i_idx (w_rom_idx),
        .o_cmd (w_rom_cmd)
    );

`ifdef VDP_BOOT_VRAM_CLEAR_EN
    localparam int WORD_W = $clog2(VRAM_WORDS);

    phase_t            r_phase;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_inc;

    always_comb begin
        w_word_inc = r_word + 1'b1;
        w_next_cmd = w_rom_cmd;
        w_finish   = 1'b0;
        case (r_phase)
            PH_TABLE: begin
                if (r_idx == LAST_IDX)
                    w_next_cmd = make_cmd(VDP_PORT_CTRL, VRAM_WR_ADDR_HI);
            end
            PH_CLR_ADDR_HI: w_next_cmd = make_cmd(VDP_PORT_CTRL, VRAM_WR_ADDR_LO);
            PH_CLR_ADDR_LO: w_next_cmd = make_cmd(VDP_PORT_DATA, 16'h0000);
            PH_CLR_DATA: begin
                w_next_cmd = make_cmd(VDP_PORT_DATA, 16'h0000);
                // last word written when the counter would wrap back to zero
                w_finish   = (w_word_inc == '0);
            end
            default: w_next_cmd = w_rom_cmd;
        endcase
    end
`else
    assign w_next_cmd = w_rom_cmd;
    assign w_finish   = (r_idx == LAST_IDX);
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_sel   <= 1'b0;
            r_a     <= '0;
            r_rnw   <= 1'b1;
            r_uds_n <= 1'b1;
            r_lds_n <= 1'b1;
            r_di    <= '0;
`ifdef VDP_BOOT_VRAM_CLEAR_EN
            r_phase <= PH_TABLE;
            r_word  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_a     <= w_rom_cmd.a;
                        r_di    <= w_rom_cmd.data;
                        r_rnw   <= 1'b0;
                        r_uds_n <= 1'b0;
                        r_lds_n <= 1'b0;
                        r_state <= ST_SETUP;
`ifdef VDP_BOOT_VRAM_CLEAR_EN
                        r_phase <= PH_TABLE;
                        r_word  <= '0;
`endif
                    end
                end
                // address, data and strobes have been stable for one cycle
                ST_SETUP: begin
                    r_sel   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (w_ack) begin
                        r_sel   <= 1'b0;
                        r_state <= ST_RELEASE;
                    end else if (w_tmo) begin
                        r_sel   <= 1'b0;
                        r_rnw   <= 1'b1;
                        r_uds_n <= 1'b1;
                        r_lds_n <= 1'b1;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= ST_ERROR;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                ST_RELEASE: begin
                    r_rnw   <= 1'b1;
                    r_uds_n <= 1'b1;
                    r_lds_n <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_IDLE;
                end
                // DTACK must be seen high again before the next cycle may start
                ST_WAIT_IDLE: begin
                    if (!w_ack) begin
                        r_state <= ST_NEXT;
                    end else if (w_tmo) begin
                        r_sel   <= 1'b0;
                        r_rnw   <= 1'b1;
                        r_uds_n <= 1'b1;
                        r_lds_n <= 1'b1;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= ST_ERROR;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                ST_NEXT: begin
                    if (w_finish) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_a     <= w_next_cmd.a;
                        r_di    <= w_next_cmd.data;
                        r_rnw   <= 1'b0;
                        r_uds_n <= 1'b0;
                        r_lds_n <= 1'b0;
                        r_state <= ST_SETUP;
`ifdef VDP_BOOT_VRAM_CLEAR_EN
                        case (r_phase)
                            PH_TABLE: begin
                                if (r_idx == LAST_IDX)
                                    r_phase <= PH_CLR_ADDR_HI;
                                else
                                    r_idx <= r_idx + 6'd1;
                            end
                            PH_CLR_ADDR_HI: r_phase <= PH_CLR_ADDR_LO;
                            PH_CLR_ADDR_LO: r_phase <= PH_CLR_DATA;
                            PH_CLR_DATA:    r_word  <= w_word_inc;
                            default:        r_phase <= PH_TABLE;
                        endcase
`else
                        r_idx <= r_idx + 6'd1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign vdp_sel   = r_sel;
    assign vdp_a     = r_a;
    assign vdp_rnw   = r_rnw;
    assign vdp_uds_n = r_uds_n;
    assign vdp_lds_n = r_lds_n;
    assign vdp_di    = r_di;

endmodule

// File: tb/tb_vdp_boot_sequencer.sv
// Scoreboard bench for vdp_boot_sequencer: a DTACK-driving VDP model, expected host
// writes queued by the stimulus and popped by a monitor on each SEL assertion.
module tb_vdp_boot_sequencer;

    localparam int TMO = 4096;
`ifdef VDP_BOOT_VRAM_CLEAR_EN
    localparam int TOTAL_WR = 4 + 2 + 32768;
    localparam int RUN_BUDGET = 1200000;
`else
    localparam int TOTAL_WR = 4;
    localparam int RUN_BUDGET = 2000;
`endif

    logic        CLK100MHZ;
    logic        CPU_RESETN;
    logic        start;
    logic        busy, done, error;
    logic        vdp_sel;
    logic [4:0]  vdp_a;
    logic        vdp_rnw, vdp_uds_n, vdp_lds_n;
    logic [15:0] vdp_di;
    logic        vdp_dtack_n;

    vdp_boot_sequencer dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .vdp_sel     (vdp_sel),
        .vdp_a       (vdp_a),
        .vdp_rnw     (vdp_rnw),
        .vdp_uds_n   (vdp_uds_n),
        .vdp_lds_n   (vdp_lds_n),
        .vdp_di      (vdp_di),
        .vdp_dtack_n (vdp_dtack_n)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0;
    logic [23:0] sb[$];

    // VDP model controls
    bit ack_en = 1'b1;
    int ack_dly = 3;
    int hold_after = 0;
    bit hold_mode = 1'b0;
    bit rise_valid = 1'b0;
    int rise_cyc = 0;

    // record layout: {a[4:0], data[15:0], rnw, uds_n, lds_n}
    logic [23:0] exp_tab [4] = '{
        {5'h04, 16'h8004, 3'b000},
        {5'h04, 16'h8144, 3'b000},
        {5'h04, 16'h8230, 3'b000},
        {5'h04, 16'h8C81, 3'b000}
    };

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    initial forever begin
        @(posedge CLK100MHZ);
        cyc++;
    end

    initial begin
        int sel_cnt;
        int hold_cnt;
        sel_cnt = 0;
        hold_cnt = 0;
        vdp_dtack_n = 1'b1;
        forever begin
            @(posedge CLK100MHZ);
            #1;
            if (vdp_sel) begin
                hold_cnt = 0;
                if (ack_en) begin
                    sel_cnt++;
                    if (sel_cnt >= ack_dly) vdp_dtack_n = 1'b0;
                end
            end else begin
                sel_cnt = 0;
                if (!vdp_dtack_n) begin
                    if (hold_cnt >= hold_after) begin
                        vdp_dtack_n = 1'b1;
                        rise_cyc = cyc;
                        rise_valid = 1'b1;
                        hold_cnt = 0;
                    end else begin
                        hold_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        logic sel_q;
        logic [23:0] rec;
        logic [23:0] expv;
        int gap;
        sel_q = 1'b0;
        forever begin
            @(negedge CLK100MHZ);
            if (vdp_sel && !sel_q) begin
                rec = {vdp_a, vdp_di, vdp_rnw, vdp_uds_n, vdp_lds_n};
                wr_cnt++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got %h, nothing expected", rec);
                end else begin
                    expv = sb.pop_front();
                    if (rec !== expv) begin
                        n_err++;
                        $display("FAIL write_%0d: got a/data/rnw/strobes %h, expected %h",
                                 wr_cnt, rec, expv);
                    end
                end
                if (hold_mode && rise_valid) begin
                    gap = cyc - rise_cyc;
                    n_cmp++;
                    if (gap < 2) begin
                        n_err++;
                        $display("FAIL dtack_gap: SEL %0d cycles after DTACK rise, expected >= 2", gap);
                    end
                end
            end
            sel_q = vdp_sel;
        end
    end

    initial begin
        #100ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic push_run();
        for (int i = 0; i < 4; i++) sb.push_back(exp_tab[i]);
`ifdef VDP_BOOT_VRAM_CLEAR_EN
        sb.push_back({5'h04, 16'h4000, 3'b000});
        sb.push_back({5'h04, 16'h0000, 3'b000});
        for (int i = 0; i < 32768; i++) sb.push_back({5'h00, 16'h0000, 3'b000});
`endif
    endtask

    task automatic pulse_start();
        @(negedge CLK100MHZ);
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int i;
        for (i = 0; i < RUN_BUDGET; i++) begin
            @(negedge CLK100MHZ);
            if (done || error) break;
        end
        if (!(done || error)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: no done/error after %0d cycles", name, RUN_BUDGET);
        end
    endtask

    task automatic chk_done(input string name);
        chk({name, "_done"}, done, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_error"}, error, 0);
        chk({name, "_wr_cnt"}, wr_cnt, TOTAL_WR);
        chk({name, "_sb_left"}, sb.size(), 0);
        chk({name, "_idle_bus"}, {vdp_sel, vdp_rnw, vdp_uds_n, vdp_lds_n}, 4'b0111);
    endtask

    initial begin
        int n;
        start = 1'b0;
        CPU_RESETN = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_sel", vdp_sel, 0);
        chk("rst_rnw", vdp_rnw, 1);
        chk("rst_strobes", {vdp_uds_n, vdp_lds_n}, 2'b11);
        chk("rst_a", vdp_a, 0);
        chk("rst_di", vdp_di, 0);
        CPU_RESETN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);

        // normal boot with start-to-SEL timing
        wr_cnt = 0;
        push_run();
        pulse_start();
        chk("t1_busy_rise", busy, 1);
        chk("t1_setup_sel", vdp_sel, 0);
        chk("t1_setup_bus", {vdp_a, vdp_di, vdp_rnw, vdp_uds_n, vdp_lds_n},
            {5'h04, 16'h8004, 3'b000});
        @(negedge CLK100MHZ);
        chk("t1_sel_rise", vdp_sel, 1);
        wait_end("t1");
        chk_done("t1");

        // start while busy is ignored; start after done repeats identically
        wr_cnt = 0;
        push_run();
        pulse_start();
        chk("t2_done_clr", done, 0);
        n = 0;
        while (wr_cnt < 2 && n < 200) begin
            @(negedge CLK100MHZ);
            n++;
        end
        pulse_start();
        wait_end("t2");
        chk_done("t2");

        // DTACK held low 10 cycles after release
        wr_cnt = 0;
        hold_after = 10;
        hold_mode = 1'b1;
        rise_valid = 1'b0;
        push_run();
        pulse_start();
        wait_end("t3");
        chk_done("t3");
        hold_mode = 1'b0;
        hold_after = 0;

        // DTACK never asserts
        wr_cnt = 0;
        ack_en = 1'b0;
        sb.push_back(exp_tab[0]);
        pulse_start();
        n = 0;
        while (!vdp_sel && n < 20) begin
            @(negedge CLK100MHZ);
            n++;
        end
        n = 0;
        while (vdp_sel && n < 3 * TMO) begin
            @(negedge CLK100MHZ);
            n++;
        end
        chk("t4_sel_len", n, TMO);
        chk("t4_error", error, 1);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_bus", {vdp_sel, vdp_rnw, vdp_uds_n, vdp_lds_n}, 4'b0111);
        chk("t4_sb_left", sb.size(), 0);
        ack_en = 1'b1;
        repeat (3) @(negedge CLK100MHZ);

        // reset during WAIT_ACK of write 2, then rerun from ERROR-free reset state
        wr_cnt = 0;
        push_run();
        pulse_start();
        chk("t5_error_clr", error, 0);
        n = 0;
        while (n < 200) begin
            @(negedge CLK100MHZ);
            #1;
            n++;
            if (wr_cnt >= 2) break;
        end
        chk("t5_pre_sel", vdp_sel, 1);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        chk("t5_rst_sel", vdp_sel, 0);
        chk("t5_rst_rnw", vdp_rnw, 1);
        chk("t5_rst_busy", busy, 0);
        repeat (3) @(negedge CLK100MHZ);
        sb.delete();
        CPU_RESETN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
        wr_cnt = 0;
        push_run();
        pulse_start();
        wait_end("t5");
        chk_done("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
